sliced_addsub16_seq: RTL and testbench

- Multi-cycle 16-bit adder/subtractor that computes one SLICE-bit partition per clock and ripples the carry/borrow through a register between slices.
- It is the sequential counterpart of the combinational partitioned adder slices. It consumes operands and reassembles the full-width sum or difference, carry/borrow and signed overflow.
- Sits behind a valid/ready operand interface and drives a valid/ready result interface.
- Serves as the golden multi-cycle datapath for comparing approximated partitions.

---
 rtl/sliced_addsub16_seq.sv | 131 +++++++++++++
 tb/tb_sliced_addsub16_seq.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sliced_addsub16_seq.sv
// Multi-cycle adder/subtractor that processes one SLICE-bit partition per clock and
// carries the ripple carry/borrow through a register between slices.
module sliced_addsub16_seq #(
   parameter int WIDTH = 16,
   parameter int SLICE = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_sub,
   input  logic             in_ci,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_co,
   output logic             out_ovf
);

   localparam int NUM_SLICES = (WIDTH + SLICE - 1) / SLICE;
   localparam int LAST_W     = WIDTH - (NUM_SLICES - 1) * SLICE;
   localparam int IW         = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
   localparam int OW         = $clog2(WIDTH + SLICE);
   localparam int SW         = SLICE + 1;
   localparam logic [IW-1:0]    LAST_IDX   = IW'(NUM_SLICES - 1);
   localparam logic [WIDTH-1:0] SLICE_ONES = WIDTH'({SLICE{1'b1}});

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic [IW-1:0]    idx;
   logic             carry;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             sub_q;
   logic [WIDTH-1:0] sum_q;
   logic             co_q;
   logic             ovf_q;

   logic [OW-1:0]    offset;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [SLICE:0]   slice_sum;
   logic             slice_co;
   logic [WIDTH-1:0] wmask;
   logic [WIDTH-1:0] wdata;
   logic [WIDTH-1:0] sum_nx;

   // Slice datapath; on the narrow final slice the shifted-in zeros above LAST_W
   // leave the carry at bit LAST_W, and those upper sum bits shift past the MSB.
   always_comb begin
      offset    = OW'(idx) * OW'(SLICE);
      a_sh      = a_q >> offset;
      b_sh      = b_q >> offset;
      slice_sum = {1'b0, a_sh[SLICE-1:0]} + {1'b0, b_sh[SLICE-1:0]} + SW'(carry);
      slice_co  = (idx == LAST_IDX) ? slice_sum[LAST_W] : slice_sum[SLICE];
      wmask     = SLICE_ONES << offset;
      wdata     = WIDTH'(slice_sum[SLICE-1:0]) << offset;
      sum_nx    = (sum_q & ~wmask) | (wdata & wmask);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (in_valid) state_nx = RUN;
         RUN:     if (idx == LAST_IDX) state_nx = DONE;
         DONE:    if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx   <= '0;
         carry <= 1'b0;
         a_q   <= '0;
         b_q   <= '0;
         sub_q <= 1'b0;
         sum_q <= '0;
         co_q  <= 1'b0;
         ovf_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q   <= in_a;
                  b_q   <= in_sub ? ~in_b : in_b;
                  sub_q <= in_sub;
                  carry <= in_ci ^ in_sub;
                  idx   <= '0;
               end
            end
            RUN: begin
               sum_q <= sum_nx;
               carry <= slice_co;
               if (idx == LAST_IDX) begin
                  idx   <= '0;
                  co_q  <= slice_co ^ sub_q;
                  // b_q already holds ~B for subtract, so one equal-sign test covers both modes
                  ovf_q <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_nx[WIDTH-1] != a_q[WIDTH-1]);
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign out_sum   = sum_q;
   assign out_co    = co_q;
   assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_sliced_addsub16_seq.sv
// Directed and randomized checks for sliced_addsub16_seq: latency, arithmetic
// corner cases, backpressure, asynchronous reset and a reference-model regression.
module tb_sliced_addsub16_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_a;
   logic [15:0] in_b;
   logic        in_sub;
   logic        in_ci;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_sum;
   logic        out_co;
   logic        out_ovf;

   int checks   = 0;
   int failures = 0;

   sliced_addsub16_seq #(
      .WIDTH(16),
      .SLICE(5)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_a     (in_a),
      .in_b     (in_b),
      .in_sub   (in_sub),
      .in_ci    (in_ci),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_sum  (out_sum),
      .out_co   (out_co),
      .out_ovf  (out_ovf)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits (bounded) for in_ready, presents one operation for a single edge,
   // then scrambles the operand buses to show they are not re-sampled.
   task automatic start_op(input logic [15:0] a, input logic [15:0] b,
                           input logic sub, input logic ci, output logic was_ready);
      int n;
      n = 0;
      while (in_ready !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      was_ready = (in_ready === 1'b1);
      in_a     = a;
      in_b     = b;
      in_sub   = sub;
      in_ci    = ci;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      in_a     = ~a;
      in_b     = ~b;
      in_sub   = ~sub;
      in_ci    = ~ci;
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      while (out_valid !== 1'b1 && lat < 20) begin
         tick();
         lat++;
      end
   endtask

   task automatic take_result();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   function automatic logic [17:0] ref_model(input logic [15:0] a, input logic [15:0] b,
                                             input logic sub, input logic ci);
      logic [16:0] r;
      logic        ovf;
      if (!sub) begin
         r   = {1'b0, a} + {1'b0, b} + 17'(ci);
         ovf = (a[15] == b[15]) && (r[15] != a[15]);
      end else begin
         r   = {1'b0, a} - {1'b0, b} - 17'(ci);
         ovf = (a[15] != b[15]) && (r[15] != a[15]);
      end
      return {r[16], ovf, r[15:0]};
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks += 5;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
      if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
      if (out_sum !== 16'h0000) begin failures++; $display("FAIL reset_out_sum got=%h want=0000", out_sum); end
      if (out_co !== 1'b0) begin failures++; $display("FAIL reset_out_co got=%b want=0", out_co); end
      if (out_ovf !== 1'b0) begin failures++; $display("FAIL reset_out_ovf got=%b want=0", out_ovf); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_directed();
      logic [15:0] va [7] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0000, 16'h8000, 16'h0005, 16'hFFFF};
      logic [15:0] vb [7] = '{16'h4321, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0003, 16'hFFFF};
      logic        vs [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      logic        vc [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [15:0] es [7] = '{16'h5555, 16'h0000, 16'h8000, 16'hFFFF, 16'h7FFF, 16'h0001, 16'hFFFF};
      logic        ec [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      logic        eo [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      logic        rdy;
      int          lat;
      for (int i = 0; i < 7; i++) begin
         start_op(va[i], vb[i], vs[i], vc[i], rdy);
         wait_done(lat);
         checks += 6;
         if (rdy !== 1'b1) begin failures++; $display("FAIL dir%0d_accept got=%b want=1", i, rdy); end
         if (lat != 4) begin failures++; $display("FAIL dir%0d_latency got=%0d want=4", i, lat); end
         if (out_sum !== es[i]) begin failures++; $display("FAIL dir%0d_sum got=%h want=%h", i, out_sum, es[i]); end
         if (out_co !== ec[i]) begin failures++; $display("FAIL dir%0d_co got=%b want=%b", i, out_co, ec[i]); end
         if (out_ovf !== eo[i]) begin failures++; $display("FAIL dir%0d_ovf got=%b want=%b", i, out_ovf, eo[i]); end
         if (in_ready !== 1'b0) begin failures++; $display("FAIL dir%0d_ready_in_done got=%b want=0", i, in_ready); end
         take_result();
         checks += 2;
         if (out_valid !== 1'b0) begin failures++; $display("FAIL dir%0d_valid_drop got=%b want=0", i, out_valid); end
         if (in_ready !== 1'b1) begin failures++; $display("FAIL dir%0d_ready_back got=%b want=1", i, in_ready); end
      end
   endtask

   task automatic test_backpressure();
      logic rdy;
      int   lat;
      start_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, rdy);
      wait_done(lat);
      checks += 2;
      if (lat != 4) begin failures++; $display("FAIL bp_latency got=%0d want=4", lat); end
      if (out_sum !== 16'h1000) begin failures++; $display("FAIL bp_sum got=%h want=1000", out_sum); end
      in_a     = 16'hAAAA;
      in_b     = 16'h5555;
      in_sub   = 1'b1;
      in_ci    = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks += 5;
         if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid%0d got=%b want=1", i, out_valid); end
         if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_hold_ready%0d got=%b want=0", i, in_ready); end
         if (out_sum !== 16'h1000) begin failures++; $display("FAIL bp_hold_sum%0d got=%h want=1000", i, out_sum); end
         if (out_co !== 1'b0) begin failures++; $display("FAIL bp_hold_co%0d got=%b want=0", i, out_co); end
         if (out_ovf !== 1'b0) begin failures++; $display("FAIL bp_hold_ovf%0d got=%b want=0", i, out_ovf); end
      end
      in_valid = 1'b0;
      take_result();
      checks += 3;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b want=1", in_ready); end
      if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_release_valid got=%b want=0", out_valid); end
      if (out_sum !== 16'h1000) begin failures++; $display("FAIL bp_idle_sum_kept got=%h want=1000", out_sum); end
      for (int i = 0; i < 6; i++) begin
         tick();
         checks++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_no_capture%0d got valid=%b ready=%b want valid=0 ready=1", i, out_valid, in_ready);
         end
      end
   endtask

   task automatic test_reset_mid_run();
      logic rdy;
      int   lat;
      start_op(16'h1234, 16'h4321, 1'b0, 1'b0, rdy);
      tick();
      tick();
      #2;
      rst      = 1'b1;
      in_valid = 1'b1;
      in_a     = 16'h0101;
      in_b     = 16'h0202;
      #1;
      checks += 5;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL rr_in_ready got=%b want=1", in_ready); end
      if (out_valid !== 1'b0) begin failures++; $display("FAIL rr_out_valid got=%b want=0", out_valid); end
      if (out_sum !== 16'h0000) begin failures++; $display("FAIL rr_out_sum got=%h want=0000", out_sum); end
      if (out_co !== 1'b0) begin failures++; $display("FAIL rr_out_co got=%b want=0", out_co); end
      if (out_ovf !== 1'b0) begin failures++; $display("FAIL rr_out_ovf got=%b want=0", out_ovf); end
      tick();
      tick();
      in_valid = 1'b0;
      #2;
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         checks++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rr_quiet%0d got valid=%b ready=%b want valid=0 ready=1", i, out_valid, in_ready);
         end
      end
      start_op(16'h0001, 16'h0002, 1'b0, 1'b1, rdy);
      wait_done(lat);
      checks += 2;
      if (lat != 4) begin failures++; $display("FAIL rr_after_latency got=%0d want=4", lat); end
      if (out_sum !== 16'h0004) begin failures++; $display("FAIL rr_after_sum got=%h want=0004", out_sum); end
      take_result();
   endtask

   task automatic test_random();
      logic [15:0] a;
      logic [15:0] b;
      logic        sub;
      logic        ci;
      logic [17:0] exp_r;
      logic        rdy;
      int          lat;
      int          stall;
      for (int i = 0; i < 1500; i++) begin
         a     = 16'($urandom);
         b     = 16'($urandom);
         sub   = 1'($urandom);
         ci    = 1'($urandom);
         exp_r = ref_model(a, b, sub, ci);
         start_op(a, b, sub, ci, rdy);
         wait_done(lat);
         stall = int'($urandom_range(0, 3));
         for (int s = 0; s < stall; s++) tick();
         checks += 5;
         if (rdy !== 1'b1) begin failures++; $display("FAIL rnd%0d_accept got=%b want=1", i, rdy); end
         if (lat != 4) begin failures++; $display("FAIL rnd%0d_latency got=%0d want=4", i, lat); end
         if (out_sum !== exp_r[15:0]) begin
            failures++;
            $display("FAIL rnd%0d_sum a=%h b=%h sub=%b ci=%b got=%h want=%h", i, a, b, sub, ci, out_sum, exp_r[15:0]);
         end
         if (out_co !== exp_r[17]) begin
            failures++;
            $display("FAIL rnd%0d_co a=%h b=%h sub=%b ci=%b got=%b want=%b", i, a, b, sub, ci, out_co, exp_r[17]);
         end
         if (out_ovf !== exp_r[16]) begin
            failures++;
            $display("FAIL rnd%0d_ovf a=%h b=%h sub=%b ci=%b got=%b want=%b", i, a, b, sub, ci, out_ovf, exp_r[16]);
         end
         take_result();
      end
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_sub    = 1'b0;
      in_ci     = 1'b0;
      out_ready = 1'b0;
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_mid_run();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1);
   end

endmodule
